alu_seq: RTL

Registered, parametrised successor to the team's combinational ALU. It adds a valid/ready handshake on both sides, a configurable datapath width, signed compare, three shifts, and an optional iterative multiplier. It sits between the decode/issue stage and writeback. Single-cycle ops sustain one result per clock; multiply stalls issue for WIDTH cycles.

---
 rtl/alu_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake on the input and output
// sides, and an optional iterative shift-add multiplier.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands/opcode presented
//   in_ready   block can accept (combinational)
//   a, b       operands; b[SHW-1:0] is the shift amount
//   alu_ctrl   opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sltu, 6 slt,
//              7 sll, 8 srl, 9 sra, A mul, B-F give 0
//   out_valid  result holds an unconsumed value
//   out_ready  consumer accepts result
//   result     registered result
//   busy       high while the multiplier iterates
//
// Build option: define ALU_SEQ_MUL_EN to turn opcode A into a WIDTH-cycle
// iterative multiply. Without it opcode A is a single-cycle op returning 0,
// busy is tied low and no multiplier state exists.

module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_next;
  logic [WIDTH-1:0] result_reg;
  logic             out_valid_reg;

  assign shamt     = b[SHW-1:0];
  assign result    = result_reg;
  assign out_valid = out_valid_reg;

  // Single-cycle function of the presented operands.
  always_comb begin
    alu_next = '0;
    case (alu_ctrl)
      4'h0:    alu_next = a + b;
      4'h1:    alu_next = a - b;
      4'h2:    alu_next = a & b;
      4'h3:    alu_next = a | b;
      4'h4:    alu_next = a ^ b;
      4'h5:    alu_next = {{(WIDTH-1){1'b0}}, (a < b)};
      4'h6:    alu_next = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'h7:    alu_next = a << shamt;
      4'h8:    alu_next = a >> shamt;
      4'h9:    alu_next = $signed(a) >>> shamt;
      default: alu_next = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [3:0]     OP_MUL   = 4'hA;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplr_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_next;
  logic [SHW-1:0]   cnt_reg;

  // Partial-product add for the current multiplier bit; on the last
  // iteration this sum is the final product.
  assign acc_next = mplr_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

  assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready);
  assign busy     = (state_reg == MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      result_reg    <= '0;
      out_valid_reg <= 1'b0;
      mcand_reg     <= '0;
      mplr_reg      <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (alu_ctrl == OP_MUL) begin
              // Any pending output is being consumed this same cycle, so
              // the output register can go invalid while we iterate.
              mcand_reg     <= a;
              mplr_reg      <= b;
              acc_reg       <= '0;
              cnt_reg       <= '0;
              out_valid_reg <= 1'b0;
              state_reg     <= MUL;
            end else begin
              result_reg    <= alu_next;
              out_valid_reg <= 1'b1;
            end
          end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        MUL: begin
          acc_reg   <= acc_next;
          mcand_reg <= mcand_reg << 1;
          mplr_reg  <= mplr_reg >> 1;
          cnt_reg   <= cnt_reg + SHW'(1);
          if (cnt_reg == CNT_LAST) begin
            result_reg    <= acc_next;
            out_valid_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`else

  assign in_ready = !out_valid_reg || out_ready;
  assign busy     = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else if (in_valid && in_ready) begin
      // Covers the simultaneous drain-and-refill case: no bubble.
      result_reg    <= alu_next;
      out_valid_reg <= 1'b1;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

`endif

endmodule
